iterative_alu: RTL and testbench
================================

Name: iterative_alu

Overview:
- Execute-stage ALU that consumes the 4-bit Operation code produced by the ALU controller, plus two operands.
- Returns a registered result and a branch-condition flag over a valid/ready handshake.
- Logic and arithmetic ops complete in 1 cycle. Shifts run serially, one bit per cycle, to save area; a compile-time option selects a single-cycle barrel shifter instead.
- Sits between ID/EX operand muxing and the EX/MEM register; the hazard unit stalls on in_ready low.

Parameters:
- DATA_WIDTH, 32, operand/result width; power of two, at least 8.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount bits taken from src_b.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- op  in  4  Operation code (encoding in Behaviour).
- src_a  in  DATA_WIDTH  operand A.
- src_b  in  DATA_WIDTH  operand B / shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  DATA_WIDTH  ALU result.
- branch_taken  out  1  branch condition true (branch ops only, else 0).
- illegal_op  out  1  op code unused; qualified by out_valid.

Behaviour:
- Op encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR
  - 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA
  - 1000 EQ (BEQ), 1001 LT signed (BLT), 1010 GE signed (BGE), 1011 SLT signed
  - 1100-1111 illegal
- Reset (async, any time, including mid-shift):
  - state=IDLE; out_valid=0; result=0; branch_taken=0; illegal_op=0; shift counter=0.
  - in_ready=1 once rst_n deasserted (IDLE).
- FSM states: IDLE, SHIFT, DONE.
  - in_ready=1 only in IDLE. A transfer occurs on in_valid&&in_ready at a rising edge; op and operands are captured then.
  - IDLE, non-shift op or shift with shamt==0 -> DONE. Result is registered that edge, so out_valid rises 1 cycle after acceptance.
  - IDLE, shift op with shamt!=0 -> SHIFT. Working register=src_a, counter=shamt.
  - SHIFT: each cycle, shift working register by 1 (SLL zero-fill left; SRL zero-fill right; SRA sign-fill right) and decrement counter. When counter reaches 1 that cycle -> DONE with final value. Latency = shamt+1 cycles; max DATA_WIDTH cycles.
  - DONE: out_valid=1; result, branch_taken and illegal_op held stable until out_valid&&out_ready. Then -> IDLE. No new request is accepted in the same cycle as the result handshake (in_ready rises the following cycle).
- Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH, no flags. SLT result = {0..0, signed(a)<signed(b)}.
- Branch ops: result=0; branch_taken = condition.
- Illegal op: result=0, branch_taken=0, illegal_op=1, latency 1.
- shamt = src_b[SHAMT_WIDTH-1:0]; upper bits of src_b are ignored for shifts.
- Operand inputs are don't-care when no transfer occurs.

Optional Feature:
- Macro ALU_FAST_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter; every op has latency 1; the SHIFT state and counter are not compiled.
- Undefined: serial shifter as above.
- Results are bit-identical in both modes; only latency differs.

Decomposition:
- Shared package alu_pkg: alu_op_t enum (4-bit codes above), ALU_OP_WIDTH=4, alu_state_t enum.
- The ALU controller is updated to drive alu_op_t.
- One sub-module: alu_serial_shifter (working register, counter, done pulse), excluded from the build under ALU_FAST_SHIFT_EN.

Test Plan:
- ADD a=0xFFFFFFFF, b=1 -> result=0x00000000, out_valid 1 cycle after accept, branch_taken=0.
- SUB a=5, b=7 -> 0xFFFFFFFE; SLT a=0xFFFFFFFE, b=1 -> 1; XOR 0xF0F0F0F0 ^ 0xFF00FF00 -> 0x0FF00FF0.
- SRA a=0x80000000, b=0x3F (shamt 31) -> 0xFFFFFFFF after 32 cycles; in_ready low throughout; shamt 0 -> a unchanged, latency 1.
- BLT a=-1, b=0 -> branch_taken=1, result=0; BGE same operands -> 0; BEQ a=b=0x1234 -> 1.
- Backpressure: out_ready held low 5 cycles in DONE -> result stable, no new accept; accept resumes the cycle after the handshake.
- rst_n pulsed low mid-SLL (shamt 20, cycle 7) -> out_valid=0 immediately, in_ready=1 after release; op=1101 -> illegal_op=1, result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types: operation codes, FSM states and a shift-op helper.
// Used by the ALU controller, the iterative_alu execute unit and its interface.
package alu_pkg;

    localparam int unsigned ALU_OP_WIDTH = 4;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SRA = 4'b0111,
        ALU_BEQ = 4'b1000,
        ALU_BLT = 4'b1001,
        ALU_BGE = 4'b1010,
        ALU_SLT = 4'b1011
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input alu_op_t op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/iterative_alu_if.sv
// Request/response bus of the iterative ALU.
//   request : in_valid, in_ready, op, src_a, src_b
//   response: out_valid, out_ready, result, branch_taken, illegal_op
// master = issuing side (ID/EX), slave = the ALU.
interface iterative_alu_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    import alu_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [ALU_OP_WIDTH-1:0] op;
    logic [DATA_WIDTH-1:0]   src_a;
    logic [DATA_WIDTH-1:0]   src_b;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   result;
    logic                    branch_taken;
    logic                    illegal_op;

    modport master (
        output in_valid, op, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, branch_taken, illegal_op
    );

    modport slave (
        input  in_valid, op, src_a, src_b, out_ready,
        output in_ready, out_valid, result, branch_taken, illegal_op
    );
endinterface

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter for SLL/SRL/SRA.
// Ports: clk, rst_n; start loads data/shamt/op; shifted_c is the working
// register moved by one bit; last_c flags the cycle producing the final value.
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  alu_op_t                       op,
    input  logic [DATA_WIDTH-1:0]         data,
    input  logic [$clog2(DATA_WIDTH)-1:0] shamt,
    output logic [DATA_WIDTH-1:0]         shifted_c,
    output logic                          last_c
);
    localparam int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]  work_q;
    logic [SHAMT_WIDTH-1:0] cnt_q;
    alu_op_t                op_q;

    // Working register and remaining-bit counter; counter==0 means idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            cnt_q  <= '0;
            op_q   <= ALU_SLL;
        end else if (start) begin
            work_q <= data;
            cnt_q  <= shamt;
            op_q   <= op;
        end else if (cnt_q != '0) begin
            work_q <= shifted_c;
            cnt_q  <= cnt_q - SHAMT_WIDTH'(1);
        end
    end

    // Single-bit step in the captured direction.
    always_comb begin
        shifted_c = work_q;
        case (op_q)
            ALU_SLL: shifted_c = {work_q[DATA_WIDTH-2:0], 1'b0};
            ALU_SRL: shifted_c = {1'b0, work_q[DATA_WIDTH-1:1]};
            default: shifted_c = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
        endcase
    end

    assign last_c = (cnt_q == SHAMT_WIDTH'(1));

endmodule

// File: rtl/iterative_alu.sv
// Execute-stage ALU with valid/ready handshake and registered outputs.
// Ports: clk, rst_n (async active-low), bus (iterative_alu_if.slave).
// Logic/arith/branch ops take one cycle; shifts run one bit per cycle unless
// ALU_FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module iterative_alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    iterative_alu_if.slave bus
);
    localparam int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH);

    alu_state_t             state_q, state_d;
    alu_op_t                op_c;
    logic [DATA_WIDTH-1:0]  a_c, b_c, res_c;
    logic [SHAMT_WIDTH-1:0] shamt_c;
    logic                   lt_c, branch_c, illegal_c, accept_c;

    logic                   in_ready_q, out_valid_q, branch_q, illegal_q;
    logic [DATA_WIDTH-1:0]  result_q;

    assign op_c     = alu_op_t'(bus.op);
    assign a_c      = bus.src_a;
    assign b_c      = bus.src_b;
    assign shamt_c  = bus.src_b[SHAMT_WIDTH-1:0];
    assign lt_c     = $signed(a_c) < $signed(b_c);
    assign accept_c = bus.in_valid && (state_q == ST_IDLE);

`ifndef ALU_FAST_SHIFT_EN
    logic                  start_c, last_c;
    logic [DATA_WIDTH-1:0] shifted_c;

    assign start_c = accept_c && is_shift(op_c) && (shamt_c != '0);

    alu_serial_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_c),
        .op        (op_c),
        .data      (a_c),
        .shamt     (shamt_c),
        .shifted_c (shifted_c),
        .last_c    (last_c)
    );
`endif

    // Single-cycle result; serial shifts only use it when shamt is zero.
    always_comb begin
        res_c     = '0;
        branch_c  = 1'b0;
        illegal_c = 1'b0;
        case (op_c)
            ALU_AND: res_c = a_c & b_c;
            ALU_OR:  res_c = a_c | b_c;
            ALU_ADD: res_c = a_c + b_c;
            ALU_XOR: res_c = a_c ^ b_c;
            ALU_SUB: res_c = a_c - b_c;
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL: res_c = a_c << shamt_c;
            ALU_SRL: res_c = a_c >> shamt_c;
            ALU_SRA: res_c = DATA_WIDTH'($signed(a_c) >>> shamt_c);
`else
            ALU_SLL: res_c = a_c;
            ALU_SRL: res_c = a_c;
            ALU_SRA: res_c = a_c;
`endif
            ALU_BEQ: branch_c = (a_c == b_c);
            ALU_BLT: branch_c = lt_c;
            ALU_BGE: branch_c = !lt_c;
            ALU_SLT: res_c = {{(DATA_WIDTH-1){1'b0}}, lt_c};
            default: illegal_c = 1'b1;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_DONE;
`ifndef ALU_FAST_SHIFT_EN
                    if (start_c) state_d = ST_SHIFT;
`endif
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            ST_SHIFT: if (last_c) state_d = ST_DONE;
`endif
            ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Registered handshake flags and response payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            branch_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            if (accept_c) begin
                result_q  <= res_c;
                branch_q  <= branch_c;
                illegal_q <= illegal_c;
            end
`ifndef ALU_FAST_SHIFT_EN
            else if ((state_q == ST_SHIFT) && last_c) begin
                result_q  <= shifted_c;
                branch_q  <= 1'b0;
                illegal_q <= 1'b0;
            end
`endif
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.result       = result_q;
    assign bus.branch_taken = branch_q;
    assign bus.illegal_op   = illegal_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu: driver pushes expected responses from a
// behavioural model, monitor pops and compares when out_valid is presented.
module tb_iterative_alu;
    import alu_pkg::*;

    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iterative_alu_if #(.DATA_WIDTH(DW)) bus ();

    iterative_alu #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        br;
        logic        ill;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_hs = -1;
    int   rdy_mode = 2;      // 0 random, 1 hold low, 2 hold high
    bit   mon_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        case (rdy_mode)
            0:       bus.out_ready = ($urandom_range(0, 3) != 0);
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'b1;
        endcase
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour straight from the op table.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sh;
        logic lt;
        sh    = int'(b[4:0]);
        lt    = $signed(a) < $signed(b);
        e.res = 32'h0;
        e.br  = 1'b0;
        e.ill = 1'b0;
        e.lat = 1;
        e.acc = 0;
        e.name = "";
        case (o)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a | b;
            4'd2:  e.res = a + b;
            4'd3:  e.res = a ^ b;
            4'd4:  e.res = a << sh;
            4'd5:  e.res = a >> sh;
            4'd6:  e.res = a - b;
            4'd7:  e.res = 32'($signed(a) >>> sh);
            4'd8:  e.br  = (a == b);
            4'd9:  e.br  = lt;
            4'd10: e.br  = !lt;
            4'd11: e.res = lt ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
`ifndef ALU_FAST_SHIFT_EN
        if ((o == 4'd4 || o == 4'd5 || o == 4'd7) && sh != 0) e.lat = sh + 1;
`endif
        return e;
    endfunction

    // Issue one request (call at a falling edge); acc = cycle of accepting edge.
    task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string nm, output int acc);
        int   n;
        exp_t e;
        n   = 0;
        acc = -1;
        while (bus.in_ready !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                check({nm, " accept timeout"}, 32'd0, 32'd1);
                return;
            end
        end
        e      = model(o, a, b);
        e.name = nm;
        e.acc  = cyc + 1;
        acc    = e.acc;
        q.push_back(e);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.src_a    = a;
        bus.src_b    = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op       = 4'($urandom);
        bus.src_a    = $urandom;
        bus.src_b    = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 || mon_busy) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                check("drain timeout", 32'd0, 32'd1);
                q.delete();
                return;
            end
        end
    endtask

    // Monitor: compares each presented response and its hold behaviour.
    initial begin
        exp_t cur;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                mon_busy = 1'b0;
            end else if (bus.out_valid) begin
                if (!mon_busy) begin
                    if (q.size() == 0) begin
                        check("unexpected out_valid", 32'd1, 32'd0);
                    end else begin
                        cur = q.pop_front();
                        mon_busy = 1'b1;
                        check({cur.name, " latency"}, 32'(cyc - cur.acc + 1), 32'(cur.lat));
                        check({cur.name, " result"}, bus.result, cur.res);
                        check({cur.name, " branch_taken"}, 32'(bus.branch_taken), 32'(cur.br));
                        check({cur.name, " illegal_op"}, 32'(bus.illegal_op), 32'(cur.ill));
                    end
                end else begin
                    check({cur.name, " held result"}, bus.result, cur.res);
                    check({cur.name, " held branch"}, 32'(bus.branch_taken), 32'(cur.br));
                end
                check("in_ready while out_valid", 32'(bus.in_ready), 32'd0);
                if (bus.out_ready && mon_busy) begin
                    mon_busy = 1'b0;
                    last_hs  = cyc + 1;
                end
            end else if (q.size() != 0 && cyc >= q[0].acc) begin
                check({q[0].name, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, acc2;
        logic [31:0] ra, rb;
        bus.in_valid  = 1'b0;
        bus.op        = 4'd0;
        bus.src_a     = 32'h0;
        bus.src_b     = 32'h0;
        bus.out_ready = 1'b1;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result", bus.result, 32'h0);
        check("reset branch_taken", 32'(bus.branch_taken), 32'd0);
        check("reset illegal_op", 32'(bus.illegal_op), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 32'(bus.in_ready), 32'd1);

        // Directed cases
        send(4'd2,  32'hFFFFFFFF, 32'h1,        "ADD wrap", acc);
        send(4'd6,  32'd5,        32'd7,        "SUB", acc);
        send(4'd11, 32'hFFFFFFFE, 32'h1,        "SLT", acc);
        send(4'd3,  32'hF0F0F0F0, 32'hFF00FF00, "XOR", acc);
        send(4'd7,  32'h80000000, 32'h3F,       "SRA 31", acc);
        send(4'd7,  32'h8765ABCD, 32'h40,       "SRA 0", acc);
        send(4'd4,  32'h00000001, 32'h1,        "SLL 1", acc);
        send(4'd5,  32'h80000000, 32'h1F,       "SRL 31", acc);
        send(4'd9,  32'hFFFFFFFF, 32'h0,        "BLT", acc);
        send(4'd10, 32'hFFFFFFFF, 32'h0,        "BGE", acc);
        send(4'd8,  32'h1234,     32'h1234,     "BEQ", acc);
        drain();

        // Backpressure: response held, next accept only after handshake
        rdy_mode = 1;
        send(4'd0, 32'hDEADBEEF, 32'h0F0F0F0F, "AND held", acc);
        repeat (5) @(negedge clk);
        rdy_mode = 2;
        send(4'd1, 32'h12340000, 32'h00005678, "OR after hold", acc2);
        check("accept after handshake", 32'(acc2), 32'(last_hs + 1));
        drain();

        // Reset in the middle of a serial shift
        send(4'd4, 32'h00000ABC, 32'd20, "SLL reset", acc);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("mid-shift reset out_valid", 32'(bus.out_valid), 32'd0);
        check("mid-shift reset result", bus.result, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after mid-shift reset", 32'(bus.in_ready), 32'd1);
        send(4'b1101, 32'h55555555, 32'hAAAAAAAA, "illegal 1101", acc);
        drain();

        // Randomized traffic with random backpressure
        rdy_mode = 0;
        for (int i = 0; i < 80; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
            send(4'($urandom), ra, rb, $sformatf("rand%0d", i), acc);
        end
        drain();
        rdy_mode = 2;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
